// File: rtl/mem_stage_ext.sv
// mem_stage_ext
//   MEM pipeline stage plus MEM/WB register. Loads and stores go out over a
//   req/ack memory bus whose latency is not known in advance. While an access
//   is outstanding, o_mem_ready is held low so the hazard logic stalls the
//   front of the pipeline. Meanwhile, bubbles are fed into write-back.
//
// Ports
//   i_clk, i_rst_n         clock (rising edge), asynchronous active-low reset
//   i_freeze               external stall, holds the MEM/WB register
//   i_wb_en, i_mem_r_en,
//   i_mem_w_en, i_size,
//   i_sign_ext, i_dest,
//   i_alu_res, i_val_rm    instruction fields from EX/MEM
//   i_bus_rdata, i_bus_ack read data and one-cycle completion from memory
//   o_bus_req, o_bus_we,
//   o_bus_addr, o_bus_be,
//   o_bus_wdata            registered bus request, held stable while busy
//   o_mem_ready            low while the current access is incomplete
//   o_wb_en_out .. o_err_out  MEM/WB register outputs
module mem_stage_ext #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 32,
  parameter int          REG_W     = 4,
  parameter int unsigned BASE_ADDR = 1024,
  parameter int          TIMEOUT   = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_freeze,
  input  logic                i_wb_en,
  input  logic                i_mem_r_en,
  input  logic                i_mem_w_en,
  input  logic [1:0]          i_size,
  input  logic                i_sign_ext,
  input  logic [REG_W-1:0]    i_dest,
  input  logic [ADDR_W-1:0]   i_alu_res,
  input  logic [DATA_W-1:0]   i_val_rm,
  input  logic [DATA_W-1:0]   i_bus_rdata,
  input  logic                i_bus_ack,
  output logic                o_bus_req,
  output logic                o_bus_we,
  output logic [ADDR_W-1:0]   o_bus_addr,
  output logic [DATA_W/8-1:0] o_bus_be,
  output logic [DATA_W-1:0]   o_bus_wdata,
  output logic                o_mem_ready,
  output logic                o_wb_en_out,
  output logic                o_mem_r_en_out,
  output logic [REG_W-1:0]    o_dest_out,
  output logic [ADDR_W-1:0]   o_alu_res_out,
  output logic [DATA_W-1:0]   o_mem_out,
  output logic                o_err_out
);

  localparam int NB     = DATA_W / 8;
  localparam int HALVES = NB / 2;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  logic [ADDR_W-1:0]   w_eff;
  logic [LANE_W-1:0]   w_lane;
  logic                w_is_byte;
  logic                w_is_half;
  logic                w_is_word;
  logic                w_access;
  logic                w_misaligned;
  logic                w_ready;
  logic                w_load_ok;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [NB-1:0]       w_be;
  logic [DATA_W-1:0]   w_wdata;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [DATA_W-1:0]   w_fmt;

  assign w_eff        = i_alu_res - ADDR_W'(BASE_ADDR);
  assign w_lane       = w_eff[LANE_W-1:0];
  assign w_is_byte    = (i_size == 2'b00);
  assign w_is_half    = (i_size == 2'b01);
  assign w_is_word    = i_size[1];
  assign w_access     = i_mem_r_en | i_mem_w_en;
  assign w_misaligned = (w_is_half && w_lane[0]) || (w_is_word && (w_lane != '0));
  assign w_cnt_next   = r_cnt + CNT_W'(1);

  // Ready when nothing is pending: either idle with no memory op, or the
  // access has finished and its result is waiting to be captured.
  assign w_ready     = ((r_state == S_IDLE) && !w_access) || (r_state == S_DONE);
  assign o_mem_ready = w_ready;

  // A store wins over a load when both enables are set, so load data is only
  // written back for a pure load that completed without error.
  assign w_load_ok = (r_state == S_DONE) && i_mem_r_en && !i_mem_w_en && !r_err;

  // Byte enables and lane-replicated store data for the addressed lane(s).
  always_comb begin
    w_be    = '1;
    w_wdata = i_val_rm;
    if (w_is_byte) begin
      w_be    = NB'(1) << w_lane;
      w_wdata = {NB{i_val_rm[7:0]}};
    end else if (w_is_half) begin
      w_be    = NB'(3) << w_lane;
      w_wdata = {HALVES{i_val_rm[15:0]}};
    end
  end

  // Load formatting. This uses the latched bus data together with the size/lane
  // of the instruction that is still held in EX/MEM during the access.
  assign w_byte = r_rdata[{w_lane, 3'b000} +: 8];
  assign w_half = r_rdata[{w_lane, 3'b000} +: 16];

  always_comb begin
    w_fmt = r_rdata;
    if (w_is_byte) begin
      w_fmt      = {DATA_W{i_sign_ext & w_byte[7]}};
      w_fmt[7:0] = w_byte;
    end else if (w_is_half) begin
      w_fmt       = {DATA_W{i_sign_ext & w_half[15]}};
      w_fmt[15:0] = w_half;
    end
  end

  // Access FSM. DONE is held under freeze, which keeps a stalled instruction
  // from launching a second bus cycle. A misaligned access skips the bus and
  // goes straight to DONE with an error. In BUSY, ack is tested before the
  // timeout, so an ack arriving in the final allowed cycle still succeeds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_be    <= '0;
      o_bus_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_misaligned) begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_state     <= S_BUSY;
              r_cnt       <= '0;
              r_err       <= 1'b0;
              o_bus_req   <= 1'b1;
              o_bus_we    <= i_mem_w_en;
              o_bus_addr  <= {w_eff[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
              o_bus_be    <= w_be;
              o_bus_wdata <= w_wdata;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= w_cnt_next;
          if (i_bus_ack) begin
            r_state   <= S_DONE;
            r_rdata   <= i_bus_rdata;
            r_err     <= 1'b0;
            o_bus_req <= 1'b0;
          end else if (w_cnt_next == CNT_W'(TIMEOUT)) begin
            r_state   <= S_DONE;
            r_rdata   <= '0;
            r_err     <= 1'b1;
            o_bus_req <= 1'b0;
          end
        end
        S_DONE: begin
          if (!i_freeze) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // MEM/WB register. While an access is outstanding, a bubble is loaded
  // (write-back disabled) and the data fields keep their previous values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_en_out    <= 1'b0;
      o_mem_r_en_out <= 1'b0;
      o_dest_out     <= '0;
      o_alu_res_out  <= '0;
      o_mem_out      <= '0;
      o_err_out      <= 1'b0;
    end else if (!i_freeze) begin
      if (w_ready) begin
        o_wb_en_out    <= i_wb_en;
        o_mem_r_en_out <= i_mem_r_en;
        o_dest_out     <= i_dest;
        o_alu_res_out  <= i_alu_res;
        o_mem_out      <= w_load_ok ? w_fmt : '0;
        o_err_out      <= (r_state == S_DONE) ? r_err : 1'b0;
      end else begin
        o_wb_en_out    <= 1'b0;
        o_mem_r_en_out <= 1'b0;
        o_err_out      <= 1'b0;
      end
    end
  end

endmodule
